// File: rtl/score_keeper.sv
// Two-digit BCD game score with an IDLE/PLAY/WIN state machine.
// Inputs are edge-detected here; all outputs come straight from registers.
module score_keeper #(
  parameter int WIN_SCORE = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic       playing,
  output logic       win,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2
  } state_e;

  localparam logic [3:0] WIN_TENS = 4'(WIN_SCORE / 10);
  localparam logic [3:0] WIN_ONES = 4'(WIN_SCORE % 10);

  state_e     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       playing_q, playing_d;
  logic       win_q, win_d;
  logic       start_q, hit_q, miss_q;

  logic       start_e, hit_e, miss_e;
  logic [3:0] inc_ones, inc_tens;
  logic [3:0] dec_ones, dec_tens;
  logic [3:0] upd_ones, upd_tens;

  assign start_e = start & ~start_q;
  assign hit_e   = hit   & ~hit_q;
  assign miss_e  = miss  & ~miss_q;

  // BCD increment; the 99 wrap cannot occur because play stops at WIN_SCORE.
  always_comb begin
    inc_ones = ones_q;
    inc_tens = tens_q;
    if (ones_q == 4'd9) begin
      inc_ones = 4'd0;
      inc_tens = tens_q + 4'd1;
    end else begin
      inc_ones = ones_q + 4'd1;
    end
  end

  // BCD decrement with a floor at 00.
  always_comb begin
    dec_ones = ones_q;
    dec_tens = tens_q;
    if (ones_q == 4'd0) begin
      if (tens_q != 4'd0) begin
        dec_ones = 4'd9;
        dec_tens = tens_q - 4'd1;
      end
    end else begin
      dec_ones = ones_q - 4'd1;
    end
  end

  always_comb begin
    upd_ones = ones_q;
    upd_tens = tens_q;
    if (hit_e && !miss_e) begin
      upd_ones = inc_ones;
      upd_tens = inc_tens;
    end else if (miss_e && !hit_e) begin
      upd_ones = dec_ones;
      upd_tens = dec_tens;
    end
  end

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    unique case (state_q)
      ST_IDLE, ST_WIN: begin
        if (start_e) begin
          state_d = ST_PLAY;
          ones_d  = 4'd0;
          tens_d  = 4'd0;
        end
      end
      ST_PLAY: begin
        if (start_e) begin
          ones_d = 4'd0;
          tens_d = 4'd0;
        end else begin
          ones_d = upd_ones;
          tens_d = upd_tens;
          if (upd_ones == WIN_ONES && upd_tens == WIN_TENS) state_d = ST_WIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ones_d  = 4'd0;
        tens_d  = 4'd0;
      end
    endcase
    playing_d = (state_d == ST_PLAY);
    win_d     = (state_d == ST_WIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      playing_q <= 1'b0;
      win_q     <= 1'b0;
      start_q   <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      playing_q <= playing_d;
      win_q     <= win_d;
      start_q   <= start;
      hit_q     <= hit;
      miss_q    <= miss;
    end
  end

  assign score_ones = ones_q;
  assign score_tens = tens_q;
  assign playing    = playing_q;
  assign win        = win_q;
  assign state_dbg  = state_q;

endmodule
